// File: rtl/sdram_write_arbiter_pkg.sv
// Shared arbiter states, port indices and the winner-selection helper.
// Fixed priority is selected by defining SDRAM_ARB_FIXED_PRIORITY_EN.
package sdram_write_arbiter_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    localparam logic PORT_TERMINAL = 1'b0;
    localparam logic PORT_AUX      = 1'b1;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // On a tie the port that was not served last wins; passing PORT_AUX as the
    // last grant therefore gives port 0 fixed priority.
    function automatic logic pick_winner(input logic [1:0] pending, input logic last_grant);
        if (pending == 2'b11) begin
            return ~last_grant;
        end else if (pending[PORT_TERMINAL]) begin
            return PORT_TERMINAL;
        end else begin
            return PORT_AUX;
        end
    endfunction

endpackage

// File: rtl/sdram_write_port.sv
// One writer's request latch: holds the fields of a single outstanding write and
// flags a protocol error when the writer requests again before completion.
module sdram_write_port
    import sdram_write_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 23,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BURST_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   request,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [3:0]             mask,
    input  logic [BURST_WIDTH-1:0] burst_length,
    input  logic                   clear,
    output logic                   pending,
    output logic [ADDR_WIDTH-1:0]  lat_address,
    output logic [DATA_WIDTH-1:0]  lat_data,
    output logic [3:0]             lat_mask,
    output logic [BURST_WIDTH-1:0] lat_burst_length,
    output logic                   error
);

    logic                   pending_q;
    logic [ADDR_WIDTH-1:0]  address_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [3:0]             mask_q;
    logic [BURST_WIDTH-1:0] burst_length_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q      <= FALSE;
            address_q      <= '0;
            data_q         <= '0;
            mask_q         <= 4'hF;
            burst_length_q <= BURST_WIDTH'(1);
        end else begin
            if (request && !pending_q) begin
                pending_q      <= TRUE;
                address_q      <= address;
                data_q         <= data;
                mask_q         <= mask;
                burst_length_q <= burst_length;
            end
            // Clear only hits a pending port, so it never races a fresh latch.
            if (clear) begin
                pending_q <= FALSE;
            end
        end
    end

    assign pending          = pending_q;
    assign lat_address      = address_q;
    assign lat_data         = data_q;
    assign lat_mask         = mask_q;
    assign lat_burst_length = burst_length_q;
    assign error            = request & pending_q;

endmodule

// File: rtl/sdram_write_arbiter.sv
// Two-port arbiter for the SDRAM write channel (terminal stream + aux uploader).
// Define SDRAM_ARB_FIXED_PRIORITY_EN to make port 0 win every tie.
module sdram_write_arbiter
    import sdram_write_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 23,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BURST_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  req0_address,
    input  logic                   req0_request,
    input  logic [DATA_WIDTH-1:0]  req0_data,
    input  logic [3:0]             req0_mask,
    input  logic [BURST_WIDTH-1:0] req0_burst_length,
    output logic                   req0_done,
    input  logic [ADDR_WIDTH-1:0]  req1_address,
    input  logic                   req1_request,
    input  logic [DATA_WIDTH-1:0]  req1_data,
    input  logic [3:0]             req1_mask,
    input  logic [BURST_WIDTH-1:0] req1_burst_length,
    output logic                   req1_done,
    output logic [ADDR_WIDTH-1:0]  wr_address,
    output logic                   wr_request,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic [3:0]             wr_mask,
    output logic [BURST_WIDTH-1:0] wr_burst_length,
    input  logic                   wr_done,
    output logic                   protocol_error
);

    logic [1:0]             pending;
    logic [1:0]             port_error;
    logic [1:0]             clear;
    logic [ADDR_WIDTH-1:0]  lat_address      [2];
    logic [DATA_WIDTH-1:0]  lat_data         [2];
    logic [3:0]             lat_mask         [2];
    logic [BURST_WIDTH-1:0] lat_burst_length [2];

    sdram_write_port #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .BURST_WIDTH (BURST_WIDTH)
    ) u_port0 (
        .clk              (clk),
        .reset            (reset),
        .request          (req0_request),
        .address          (req0_address),
        .data             (req0_data),
        .mask             (req0_mask),
        .burst_length     (req0_burst_length),
        .clear            (clear[0]),
        .pending          (pending[0]),
        .lat_address      (lat_address[0]),
        .lat_data         (lat_data[0]),
        .lat_mask         (lat_mask[0]),
        .lat_burst_length (lat_burst_length[0]),
        .error            (port_error[0])
    );

    sdram_write_port #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .BURST_WIDTH (BURST_WIDTH)
    ) u_port1 (
        .clk              (clk),
        .reset            (reset),
        .request          (req1_request),
        .address          (req1_address),
        .data             (req1_data),
        .mask             (req1_mask),
        .burst_length     (req1_burst_length),
        .clear            (clear[1]),
        .pending          (pending[1]),
        .lat_address      (lat_address[1]),
        .lat_data         (lat_data[1]),
        .lat_mask         (lat_mask[1]),
        .lat_burst_length (lat_burst_length[1]),
        .error            (port_error[1])
    );

    arb_state_e             state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   winner;
    logic                   last_grant;
    logic [ADDR_WIDTH-1:0]  wr_address_q, wr_address_d;
    logic                   wr_request_q, wr_request_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [3:0]             wr_mask_q, wr_mask_d;
    logic [BURST_WIDTH-1:0] wr_burst_length_q, wr_burst_length_d;
    logic [1:0]             done_q, done_d;
    logic                   protocol_error_q, protocol_error_d;

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
    assign last_grant = PORT_AUX;
`else
    logic last_grant_q, last_grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= PORT_AUX;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant   = last_grant_q;
    assign last_grant_d = (state_q == StBusy && wr_done) ? grant_q : last_grant_q;
`endif

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        winner            = pick_winner(pending, last_grant);
        wr_address_d      = wr_address_q;
        wr_request_d      = FALSE;
        wr_data_d         = wr_data_q;
        wr_mask_d         = wr_mask_q;
        wr_burst_length_d = wr_burst_length_q;
        done_d            = 2'b00;
        clear             = 2'b00;
        protocol_error_d  = protocol_error_q | (|port_error);

        unique case (state_q)
            StIdle: begin
                if (|pending) begin
                    wr_address_d      = lat_address[winner];
                    wr_data_d         = lat_data[winner];
                    wr_mask_d         = lat_mask[winner];
                    wr_burst_length_d = lat_burst_length[winner];
                    wr_request_d      = TRUE;
                    grant_d           = winner;
                    state_d           = StBusy;
                end
            end
            StBusy: begin
                if (wr_done) begin
                    done_d[grant_q] = TRUE;
                    clear[grant_q]  = TRUE;
                    state_d         = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StIdle;
            grant_q           <= PORT_TERMINAL;
            wr_address_q      <= '0;
            wr_request_q      <= FALSE;
            wr_data_q         <= '0;
            wr_mask_q         <= 4'hF;
            wr_burst_length_q <= BURST_WIDTH'(1);
            done_q            <= 2'b00;
            protocol_error_q  <= FALSE;
        end else begin
            state_q           <= state_d;
            grant_q           <= grant_d;
            wr_address_q      <= wr_address_d;
            wr_request_q      <= wr_request_d;
            wr_data_q         <= wr_data_d;
            wr_mask_q         <= wr_mask_d;
            wr_burst_length_q <= wr_burst_length_d;
            done_q            <= done_d;
            protocol_error_q  <= protocol_error_d;
        end
    end

    assign wr_address      = wr_address_q;
    assign wr_request      = wr_request_q;
    assign wr_data         = wr_data_q;
    assign wr_mask         = wr_mask_q;
    assign wr_burst_length = wr_burst_length_q;
    assign req0_done       = done_q[PORT_TERMINAL];
    assign req1_done       = done_q[PORT_AUX];
    assign protocol_error  = protocol_error_q;

endmodule

// File: tb/tb_sdram_write_arbiter.sv
// Bench for sdram_write_arbiter: directed vector table, corner sequences and a
// randomized run against a behavioural model of the arbitration rules.
module tb_sdram_write_arbiter;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int BW = 9;
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    localparam logic [AW-1:0] P0A = 23'h000100;
    localparam logic [AW-1:0] P1A = 23'h000200;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] a0, a1;
    logic          r0, r1;
    logic [DW-1:0] d0, d1;
    logic [3:0]    m0, m1;
    logic [BW-1:0] b0, b1;
    logic          dn0, dn1;
    logic [AW-1:0] wr_address;
    logic          wr_request;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_mask;
    logic [BW-1:0] wr_burst_length;
    logic          wr_done;
    logic          perr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdram_write_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .req0_address      (a0),
        .req0_request      (r0),
        .req0_data         (d0),
        .req0_mask         (m0),
        .req0_burst_length (b0),
        .req0_done         (dn0),
        .req1_address      (a1),
        .req1_request      (r1),
        .req1_data         (d1),
        .req1_mask         (m1),
        .req1_burst_length (b1),
        .req1_done         (dn1),
        .wr_address        (wr_address),
        .wr_request        (wr_request),
        .wr_data           (wr_data),
        .wr_mask           (wr_mask),
        .wr_burst_length   (wr_burst_length),
        .wr_done           (wr_done),
        .protocol_error    (perr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs, advance through one rising edge, settle 1 time unit after it.
    task automatic drive(input bit rst, input bit q0, input bit q1, input bit dn);
        reset   = rst;
        r0      = q0;
        r1      = q1;
        wr_done = dn;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit            rst, q0, q1, dn;
        bit            e_req, e_d0, e_d1, e_err;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit rst, bit q0, bit q1, bit dn, bit e_req, bit e_d0, bit e_d1,
                                bit e_err, logic [AW-1:0] e_addr);
        vec_t v;
        v.rst = rst; v.q0 = q0; v.q1 = q1; v.dn = dn;
        v.e_req = e_req; v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_err = e_err; v.e_addr = e_addr;
        return v;
    endfunction

    // Behavioural model: per-port slot, busy flag, grant and last-served port.
    typedef struct packed {
        bit            pend;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    m;
        logic [BW-1:0] b;
    } slot_t;

    slot_t         slot [2];
    bit            m_busy;
    int            m_grant, m_last;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [3:0]    e_mask;
    logic [BW-1:0] e_burst;
    bit            e_req, e_err;
    bit [1:0]      e_dn;

    task automatic model_edge();
        slot_t snap [2];
        int    w;
        int    clr;
        e_req = 1'b0;
        e_dn  = 2'b00;
        if (reset) begin
            for (int p = 0; p < 2; p++) slot[p].pend = 1'b0;
            m_busy = 1'b0; m_last = 1; m_grant = 0;
            e_addr = '0; e_data = '0; e_mask = 4'hF; e_burst = 9'd1; e_err = 1'b0;
            return;
        end
        snap[0] = slot[0];
        snap[1] = slot[1];
        clr = -1;
        if (m_busy) begin
            if (wr_done) begin
                e_dn[m_grant] = 1'b1;
                m_last = m_grant;
                m_busy = 1'b0;
                clr = m_grant;
            end
        end else if (snap[0].pend || snap[1].pend) begin
            if (snap[0].pend && snap[1].pend) w = FIXED ? 0 : 1 - m_last;
            else w = snap[0].pend ? 0 : 1;
            e_addr = snap[w].a; e_data = snap[w].d; e_mask = snap[w].m; e_burst = snap[w].b;
            e_req = 1'b1; m_grant = w; m_busy = 1'b1;
        end
        if (r0) begin
            if (snap[0].pend) e_err = 1'b1;
            else slot[0] = '{pend: 1'b1, a: a0, d: d0, m: m0, b: b0};
        end
        if (r1) begin
            if (snap[1].pend) e_err = 1'b1;
            else slot[1] = '{pend: 1'b1, a: a1, d: d1, m: m1, b: b1};
        end
        if (clr >= 0) slot[clr].pend = 1'b0;
    endtask

    initial begin
        bit tie1;
        reset = 1'b1; r0 = 1'b0; r1 = 1'b0; wr_done = 1'b0;
        a0 = P0A; d0 = 32'hDEADBEEF; m0 = 4'hF; b0 = 9'd1;
        a1 = P1A; d1 = 32'h12345678; m1 = 4'h3; b1 = 9'd4;

        // Tie after a port-0-only transaction: round robin serves port 1 first.
        tie1 = !FIXED;
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, '0));
        vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, '0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, P0A));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, P0A));
        vt.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, P0A));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, P0A));
        vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, '0));
        vt.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, '0));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, P0A));
        vt.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, P0A));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, P1A));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, P1A));
        vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, P1A));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, P0A));
        vt.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, P0A));
        vt.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, P0A));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, tie1 ? P1A : P0A));
        vt.push_back(mk(0, 0, 0, 1, 0, !tie1, tie1, 0, tie1 ? P1A : P0A));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, tie1 ? P0A : P1A));
        vt.push_back(mk(0, 0, 0, 1, 0, tie1, !tie1, 0, tie1 ? P0A : P1A));
        vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, tie1 ? P0A : P1A));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].q0, vt[i].q1, vt[i].dn);
            check($sformatf("vec%0d wr_request", i), 64'(wr_request), 64'(vt[i].e_req));
            check($sformatf("vec%0d req0_done", i), 64'(dn0), 64'(vt[i].e_d0));
            check($sformatf("vec%0d req1_done", i), 64'(dn1), 64'(vt[i].e_d1));
            check($sformatf("vec%0d protocol_error", i), 64'(perr), 64'(vt[i].e_err));
            check($sformatf("vec%0d wr_address", i), 64'(wr_address), 64'(vt[i].e_addr));
        end

        // Long burst from port 0 with port 1 requesting mid-burst.
        a0 = '0; d0 = 32'hCAFEF00D; b0 = 9'd32; d1 = 32'h55AA55AA;
        drive(1, 0, 0, 0);
        check("rst wr_mask", 64'(wr_mask), 64'hF);
        check("rst wr_burst", 64'(wr_burst_length), 64'd1);
        check("rst wr_data", 64'(wr_data), 64'd0);
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        check("burst grant req", 64'(wr_request), 64'd1);
        check("burst grant len", 64'(wr_burst_length), 64'd32);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, i == 2, 0);
            check("burst data hold", 64'(wr_data), 64'hCAFEF00D);
            check("burst req low", 64'(wr_request), 64'd0);
        end
        drive(0, 0, 0, 1);
        check("burst done0", 64'(dn0), 64'd1);
        check("burst data at done", 64'(wr_data), 64'hCAFEF00D);
        drive(0, 0, 0, 0);
        check("burst p1 grant req", 64'(wr_request), 64'd1);
        check("burst p1 data", 64'(wr_data), 64'h55AA55AA);
        check("burst p1 mask", 64'(wr_mask), 64'h3);
        drive(0, 0, 0, 1);
        check("burst done1", 64'(dn1), 64'd1);

        // Second request on a pending port: ignored, error sticks until reset.
        a0 = P0A; d0 = 32'hDEADBEEF; b0 = 9'd1; a1 = P1A; d1 = 32'h11111111;
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 0);
        check("perr clear before", 64'(perr), 64'd0);
        a1 = 23'h7FFFFF; d1 = 32'h22222222;
        drive(0, 0, 1, 0);
        check("perr set", 64'(perr), 64'd1);
        drive(0, 0, 0, 1);
        check("perr done0", 64'(dn0), 64'd1);
        drive(0, 0, 0, 0);
        check("perr p1 addr kept", 64'(wr_address), 64'(P1A));
        check("perr p1 data kept", 64'(wr_data), 64'h11111111);
        drive(0, 0, 0, 1);
        check("perr done1", 64'(dn1), 64'd1);
        check("perr held", 64'(perr), 64'd1);
        drive(1, 0, 0, 0);
        check("perr reset", 64'(perr), 64'd0);

        // Reset while busy abandons the write; a late wr_done is ignored.
        a1 = P1A;
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        check("mid grant", 64'(wr_request), 64'd1);
        drive(1, 0, 0, 0);
        check("mid rst addr", 64'(wr_address), 64'd0);
        check("mid rst data", 64'(wr_data), 64'd0);
        check("mid rst mask", 64'(wr_mask), 64'hF);
        check("mid rst burst", 64'(wr_burst_length), 64'd1);
        check("mid rst done0", 64'(dn0), 64'd0);
        drive(0, 0, 0, 1);
        check("late done0", 64'(dn0), 64'd0);
        check("late done1", 64'(dn1), 64'd0);
        drive(0, 0, 0, 0);
        check("no regrant", 64'(wr_request), 64'd0);
        check("no late done", 64'(dn0), 64'd0);

        // Randomized traffic against the model.
        reset = 1'b1; r0 = 1'b0; r1 = 1'b0; wr_done = 1'b0;
        model_edge();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 149) == 0);
            r0      = ($urandom_range(0, 3) == 0);
            r1      = ($urandom_range(0, 4) == 0);
            wr_done = ($urandom_range(0, 2) == 0);
            a0 = AW'($urandom); d0 = $urandom; m0 = 4'($urandom); b0 = BW'($urandom_range(1, 256));
            a1 = AW'($urandom); d1 = $urandom; m1 = 4'($urandom); b1 = BW'($urandom_range(1, 256));
            model_edge();
            @(posedge clk);
            #1;
            check("rnd wr_request", 64'(wr_request), 64'(e_req));
            check("rnd wr_address", 64'(wr_address), 64'(e_addr));
            check("rnd wr_data", 64'(wr_data), 64'(e_data));
            check("rnd wr_mask", 64'(wr_mask), 64'(e_mask));
            check("rnd wr_burst", 64'(wr_burst_length), 64'(e_burst));
            check("rnd req0_done", 64'(dn0), 64'(e_dn[0]));
            check("rnd req1_done", 64'(dn1), 64'(e_dn[1]));
            check("rnd protocol_error", 64'(perr), 64'(e_err));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
